// File: rtl/acl_axis_sequencer.sv
// rtl/acl_axis_sequencer.sv - ADXL345 SPI configuration and axis-read sequencer
// Optional done watchdog is compiled in when ACL_DONE_TIMEOUT_EN is defined.
module acl_axis_sequencer #(
  parameter int NUM_AXES       = 3,
  parameter int FIRST_AXIS     = 0,
  parameter int SAMPLE_W       = 10,
  parameter int BREAK_CYCLES   = 4096,
  parameter int HOLD_CYCLES    = 2097152,
  parameter int DEBOUNCE       = 3,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [7:0]                   rxdata,
  input  logic                         done,
  output logic                         transmit,
  output logic [15:0]                  txdata,
  output logic [NUM_AXES*SAMPLE_W-1:0] axis_data,
  output logic                         sample_valid,
  output logic                         config_done,
  output logic                         busy,
  output logic                         timeout_err
);

  localparam int          DATA_W    = NUM_AXES * SAMPLE_W;
  localparam logic [31:0] GAP_LAST  = 32'(BREAK_CYCLES - 1);
  localparam logic [31:0] HOLD_LAST = 32'(HOLD_CYCLES - 1);
  localparam logic [31:0] DEB_LAST  = 32'(DEBOUNCE - 1);
  localparam logic [2:0]  LAST_BYTE = 3'(2 * NUM_AXES - 1);
  localparam logic [7:0]  RD_BASE   = 8'(8'hB2 + 2 * FIRST_AXIS);
`ifdef ACL_DONE_TIMEOUT_EN
  localparam logic [31:0] TO_LAST   = 32'(TIMEOUT_CYCLES - 1);
`endif

  if (NUM_AXES < 1 || NUM_AXES > 3 || FIRST_AXIS < 0 || FIRST_AXIS + NUM_AXES > 3 ||
      SAMPLE_W < 9 || SAMPLE_W > 16 || BREAK_CYCLES < 1 || HOLD_CYCLES < 1 ||
      DEBOUNCE < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("acl_axis_sequencer: illegal parameter combination");
  end

  typedef enum logic [2:0] {
    CFG_SEND, CFG_WAIT, GAP, IDLE, RD_SEND, RD_WAIT, COMMIT, HOLD
  } state_t;

  state_t            state_q, state_d;
  logic [31:0]       cnt_q, cnt_d;
  logic [1:0]        cfg_idx_q, cfg_idx_d;
  logic [2:0]        byte_idx_q, byte_idx_d;
  logic [DATA_W-1:0] shadow_q, shadow_d;
  logic [DATA_W-1:0] axis_data_q, axis_data_d;
  logic [15:0]       txdata_q, txdata_d;
  logic              transmit_q, transmit_d;
  logic              sample_valid_q, sample_valid_d;
  logic              config_done_q, config_done_d;
  logic              busy_q, busy_d;
  logic              timeout_err_q, timeout_err_d;
  logic              abort_q, abort_d;
  logic              armed_q, armed_d;
  logic              trig_q, trig_d;
  logic [31:0]       hi_cnt_q, hi_cnt_d;
  logic [15:0]       cfg_word;
  logic [1:0]        rd_axis;

  assign rd_axis  = byte_idx_q[2:1];
  assign cfg_word = (cfg_idx_q == 2'd0) ? 16'h2D08 :
                    (cfg_idx_q == 2'd1) ? 16'h2C08 : 16'h3100;

  // Trigger: one-cycle pulse after a low followed by DEBOUNCE consecutive high samples
  always_comb begin
    armed_d  = armed_q;
    hi_cnt_d = hi_cnt_q;
    trig_d   = 1'b0;
    if (!start) begin
      armed_d  = 1'b1;
      hi_cnt_d = '0;
    end else if (armed_q) begin
      if (hi_cnt_q == DEB_LAST) begin
        trig_d   = 1'b1;
        armed_d  = 1'b0;
        hi_cnt_d = '0;
      end else begin
        hi_cnt_d = hi_cnt_q + 32'd1;
      end
    end
  end

  // Sequencer next-state and registered-output computation
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    cfg_idx_d      = cfg_idx_q;
    byte_idx_d     = byte_idx_q;
    shadow_d       = shadow_q;
    axis_data_d    = axis_data_q;
    txdata_d       = txdata_q;
    transmit_d     = 1'b0;
    sample_valid_d = 1'b0;
    config_done_d  = config_done_q;
    timeout_err_d  = timeout_err_q;
    abort_d        = abort_q;
    unique case (state_q)
      CFG_SEND: begin
        txdata_d   = cfg_word;
        transmit_d = 1'b1;
        cnt_d      = '0;
        state_d    = CFG_WAIT;
      end
      CFG_WAIT: begin
        if (done) begin
          cnt_d   = '0;
          state_d = GAP;
        end
`ifdef ACL_DONE_TIMEOUT_EN
        else if (cnt_q == TO_LAST) begin
          cnt_d         = '0;
          timeout_err_d = 1'b1;
          abort_d       = 1'b1;
          state_d       = GAP;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
`endif
      end
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d = '0;
          if (!config_done_q) begin
            // Configuration: a watchdog abort retries the same register
            if (abort_q) begin
              abort_d = 1'b0;
              state_d = CFG_SEND;
            end else if (cfg_idx_q == 2'd2) begin
              config_done_d = 1'b1;
              state_d       = IDLE;
            end else begin
              cfg_idx_d = cfg_idx_q + 2'd1;
              state_d   = CFG_SEND;
            end
          end else if (abort_q) begin
            // Read set abandoned: axis_data keeps the previous complete set
            abort_d = 1'b0;
            state_d = IDLE;
          end else if (byte_idx_q == LAST_BYTE) begin
            state_d = COMMIT;
          end else begin
            byte_idx_d = byte_idx_q + 3'd1;
            state_d    = RD_SEND;
          end
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      IDLE: begin
        if (trig_q && config_done_q) begin
          byte_idx_d = '0;
          state_d    = RD_SEND;
        end
      end
      RD_SEND: begin
        txdata_d   = {RD_BASE + {5'd0, byte_idx_q}, 8'h00};
        transmit_d = 1'b1;
        cnt_d      = '0;
        state_d    = RD_WAIT;
      end
      RD_WAIT: begin
        if (done) begin
          for (int a = 0; a < NUM_AXES; a++) begin
            if (rd_axis == 2'(a)) begin
              if (!byte_idx_q[0]) shadow_d[a*SAMPLE_W +: 8] = rxdata;
              else shadow_d[a*SAMPLE_W+8 +: SAMPLE_W-8] = rxdata[SAMPLE_W-9:0];
            end
          end
          cnt_d   = '0;
          state_d = GAP;
        end
`ifdef ACL_DONE_TIMEOUT_EN
        else if (cnt_q == TO_LAST) begin
          cnt_d         = '0;
          timeout_err_d = 1'b1;
          abort_d       = 1'b1;
          state_d       = GAP;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
`endif
      end
      COMMIT: begin
        axis_data_d    = shadow_q;
        sample_valid_d = 1'b1;
        cnt_d          = '0;
        state_d        = start ? HOLD : IDLE;
      end
      HOLD: begin
        if (!start) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (cnt_q == HOLD_LAST) begin
          cnt_d      = '0;
          byte_idx_d = '0;
          state_d    = RD_SEND;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      default: state_d = CFG_SEND;
    endcase
    busy_d = !(state_d inside {IDLE, HOLD});
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= CFG_SEND;
      cnt_q          <= '0;
      cfg_idx_q      <= '0;
      byte_idx_q     <= '0;
      shadow_q       <= '0;
      axis_data_q    <= '0;
      txdata_q       <= '0;
      transmit_q     <= 1'b0;
      sample_valid_q <= 1'b0;
      config_done_q  <= 1'b0;
      busy_q         <= 1'b0;
      timeout_err_q  <= 1'b0;
      abort_q        <= 1'b0;
      armed_q        <= 1'b0;
      trig_q         <= 1'b0;
      hi_cnt_q       <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      cfg_idx_q      <= cfg_idx_d;
      byte_idx_q     <= byte_idx_d;
      shadow_q       <= shadow_d;
      axis_data_q    <= axis_data_d;
      txdata_q       <= txdata_d;
      transmit_q     <= transmit_d;
      sample_valid_q <= sample_valid_d;
      config_done_q  <= config_done_d;
      busy_q         <= busy_d;
      timeout_err_q  <= timeout_err_d;
      abort_q        <= abort_d;
      armed_q        <= armed_d;
      trig_q         <= trig_d;
      hi_cnt_q       <= hi_cnt_d;
    end
  end

  assign transmit     = transmit_q;
  assign txdata       = txdata_q;
  assign axis_data    = axis_data_q;
  assign sample_valid = sample_valid_q;
  assign config_done  = config_done_q;
  assign busy         = busy_q;
  assign timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_acl_axis_sequencer.sv
// tb/tb_acl_axis_sequencer.sv - directed bench for acl_axis_sequencer (ACL_DONE_TIMEOUT_EN optional)
module tb_acl_axis_sequencer;

  localparam int BRK  = 8;
  localparam int HLD  = 40;
  localparam int DEB  = 3;
  localparam int TMO  = 100;
  localparam int RESP = 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_cmp = 0;
  int n_bad = 0;

  // Three-axis instance signals
  logic        rst3, start3;
  logic        done3 = 1'b0;
  logic [7:0]  rx3 = 8'h00;
  logic        tx3, sv3, cd3, busy3, to3;
  logic [15:0] txd3;
  logic [29:0] ad3;

  // Single-axis (Y) instance signals
  logic        rst1, start1;
  logic        done1 = 1'b0;
  logic [7:0]  rx1 = 8'h00;
  logic        tx1, sv1, cd1, busy1, to1;
  logic [15:0] txd1;
  logic [9:0]  ad1;

  acl_axis_sequencer #(
    .NUM_AXES(3), .FIRST_AXIS(0), .SAMPLE_W(10), .BREAK_CYCLES(BRK),
    .HOLD_CYCLES(HLD), .DEBOUNCE(DEB), .TIMEOUT_CYCLES(1000)
  ) u_dut3 (
    .clk(clk), .rst(rst3), .start(start3), .rxdata(rx3), .done(done3),
    .transmit(tx3), .txdata(txd3), .axis_data(ad3), .sample_valid(sv3),
    .config_done(cd3), .busy(busy3), .timeout_err(to3)
  );

  acl_axis_sequencer #(
    .NUM_AXES(1), .FIRST_AXIS(1), .SAMPLE_W(10), .BREAK_CYCLES(BRK),
    .HOLD_CYCLES(HLD), .DEBOUNCE(DEB), .TIMEOUT_CYCLES(TMO)
  ) u_dut1 (
    .clk(clk), .rst(rst1), .start(start1), .rxdata(rx1), .done(done1),
    .transmit(tx1), .txdata(txd1), .axis_data(ad1), .sample_valid(sv1),
    .config_done(cd1), .busy(busy1), .timeout_err(to1)
  );

  // SPI slave models: done RESP clocks after each transmit, rxdata from a byte queue
  logic [15:0] log3[$], log1[$];
  int          cyc1q[$], svcyc1[$];
  logic [9:0]  ad1_log[$];
  logic [7:0]  rxq3[$], rxq1[$];
  bit          en3 = 1'b1, en1 = 1'b1, pend3 = 1'b0, pend1 = 1'b0;
  int          cnt3 = 0, cnt1 = 0, sv3_cnt = 0, sv1_cnt = 0;

  always @(negedge clk) begin
    done3 = 1'b0;
    if (pend3) begin
      cnt3--;
      if (cnt3 == 0) begin
        pend3 = 1'b0;
        done3 = 1'b1;
        rx3   = (rxq3.size() > 0) ? rxq3.pop_front() : 8'h00;
      end
    end
    if (tx3) begin
      log3.push_back(txd3);
      pend3 = en3;
      cnt3  = RESP;
    end
    if (sv3) sv3_cnt++;
  end

  always @(negedge clk) begin
    done1 = 1'b0;
    if (pend1) begin
      cnt1--;
      if (cnt1 == 0) begin
        pend1 = 1'b0;
        done1 = 1'b1;
        rx1   = (rxq1.size() > 0) ? rxq1.pop_front() : 8'h00;
      end
    end
    if (tx1) begin
      log1.push_back(txd1);
      cyc1q.push_back(cyc);
      pend1 = en1;
      cnt1  = RESP;
    end
    if (sv1) begin
      sv1_cnt++;
      svcyc1.push_back(cyc);
      ad1_log.push_back(ad1);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  typedef struct {
    logic [7:0] b[6];
    logic [9:0] x, y, z;
  } vec_t;

  vec_t vt[3];

  initial begin
    int  base, svb, n, t0;
    bit  ok;
    logic [29:0] exp3;

    vt[0].b = '{8'h34, 8'h01, 8'h78, 8'h02, 8'hBC, 8'h03};
    vt[0].x = 10'h134; vt[0].y = 10'h278; vt[0].z = 10'h3BC;
    vt[1].b = '{8'hFF, 8'hFF, 8'h00, 8'h00, 8'h80, 8'hFE};
    vt[1].x = 10'h3FF; vt[1].y = 10'h000; vt[1].z = 10'h280;
    vt[2].b = '{8'h55, 8'hAA, 8'hAA, 8'h55, 8'h01, 8'h02};
    vt[2].x = 10'h255; vt[2].y = 10'h1AA; vt[2].z = 10'h201;

    rst3 = 1'b1; rst1 = 1'b1; start3 = 1'b0; start1 = 1'b0;
    repeat (3) step();
    check("rst_transmit", 32'(tx3), 32'd0);
    check("rst_txdata", 32'(txd3), 32'd0);
    check("rst_axis_data", 32'(ad3), 32'd0);
    check("rst_sample_valid", 32'(sv3), 32'd0);
    check("rst_config_done", 32'(cd3), 32'd0);
    check("rst_busy", 32'(busy3), 32'd0);
    check("rst_timeout_err", 32'(to3), 32'd0);

    // Configuration, with dut3 reset between its first transmit and done
    rst3 = 1'b0; rst1 = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (log3.size() >= 1) begin ok = 1'b1; break; end
    end
    check("first_tx_seen", 32'(ok), 32'd1);
    repeat (10) step();
    rst3 = 1'b1; start1 = 1'b1;
    step();
    check("midrst_transmit", 32'(tx3), 32'd0);
    check("midrst_txdata", 32'(txd3), 32'd0);
    check("midrst_busy", 32'(busy3), 32'd0);
    repeat (5) step();
    start1 = 1'b0;
    repeat (15) step();
    rst3 = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      step();
      if (cd1 && cd3) begin ok = 1'b1; break; end
    end
    check("config_done_wait", 32'(ok), 32'd1);
    check("cfg3_count", 32'(log3.size()), 32'd4);
    if (log3.size() == 4) begin
      check("cfg3_w0", 32'(log3[0]), 32'h2D08);
      check("cfg3_w1_restart", 32'(log3[1]), 32'h2D08);
      check("cfg3_w2", 32'(log3[2]), 32'h2C08);
      check("cfg3_w3", 32'(log3[3]), 32'h3100);
    end
    check("cfg1_count", 32'(log1.size()), 32'd3);
    if (log1.size() == 3) begin
      check("cfg1_w0", 32'(log1[0]), 32'h2D08);
      check("cfg1_w1", 32'(log1[1]), 32'h2C08);
      check("cfg1_w2", 32'(log1[2]), 32'h3100);
      check("cfg1_gap01", 32'((cyc1q[1] - cyc1q[0]) >= RESP + BRK), 32'd1);
      check("cfg1_gap12", 32'((cyc1q[2] - cyc1q[1]) >= RESP + BRK), 32'd1);
    end
    step();
    check("cfg_busy3", 32'(busy3), 32'd0);
    check("cfg_busy1", 32'(busy1), 32'd0);
    repeat (40) step();
    check("cfg_trig_discarded", 32'(log1.size()), 32'd3);

    // Table-driven read sets on the three-axis instance
    for (int v = 0; v < 3; v++) begin
      for (int i = 0; i < 6; i++) rxq3.push_back(vt[v].b[i]);
      exp3 = {vt[v].z, vt[v].y, vt[v].x};
      base = log3.size();
      svb  = sv3_cnt;
      start3 = 1'b1;
      repeat (4) step();
      start3 = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
        step();
        if (sv3_cnt > svb) begin ok = 1'b1; break; end
      end
      check($sformatf("rd%0d_valid_seen", v), 32'(ok), 32'd1);
      check($sformatf("rd%0d_axis_data", v), 32'(ad3), 32'(exp3));
      check($sformatf("rd%0d_tx_count", v), 32'(log3.size() - base), 32'd6);
      for (int i = 0; i < 6; i++)
        if (base + i < log3.size())
          check($sformatf("rd%0d_addr%0d", v, i), 32'(log3[base+i]), 32'(16'hB200 + 16'(i) * 16'h0100));
      repeat (20) step();
      check($sformatf("rd%0d_one_valid", v), 32'(sv3_cnt - svb), 32'd1);
      check($sformatf("rd%0d_idle", v), 32'(busy3), 32'd0);
    end

    // Short start pulse: below DEBOUNCE, no read
    base = log3.size();
    start3 = 1'b1;
    repeat (2) step();
    start3 = 1'b0;
    repeat (60) step();
    check("short_pulse_no_tx", 32'(log3.size()), 32'(base));

    // Repeated sampling while start held on the Y-only instance
    rxq1.push_back(8'h34); rxq1.push_back(8'h01);
    rxq1.push_back(8'h78); rxq1.push_back(8'h02);
    rxq1.push_back(8'hAA); rxq1.push_back(8'hFF);
    start1 = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 600; i++) begin
      step();
      if (sv1_cnt >= 2) begin ok = 1'b1; break; end
    end
    check("hold_two_sets", 32'(ok), 32'd1);
    if (ok) begin
      check("hold_set0_data", 32'(ad1_log[0]), 32'h134);
      check("hold_set1_data", 32'(ad1_log[1]), 32'h278);
      check("hold_period", 32'((svcyc1[1] - svcyc1[0]) >= HLD + 2 * (RESP + BRK)), 32'd1);
    end
    check("hold_tx_count", 32'(log1.size()), 32'd7);
    if (log1.size() >= 7) begin
      check("hold_a0", 32'(log1[3]), 32'hB400);
      check("hold_a1", 32'(log1[4]), 32'hB500);
      check("hold_a2", 32'(log1[5]), 32'hB400);
      check("hold_a3", 32'(log1[6]), 32'hB500);
    end
    repeat (10) step();
    start1 = 1'b0;
    n = log1.size();
    step();
    check("hold_drop_busy", 32'(busy1), 32'd0);
    repeat (100) step();
    check("hold_drop_no_tx", 32'(log1.size()), 32'(n));
    check("hold_drop_no_valid", 32'(sv1_cnt), 32'd2);

`ifdef ACL_DONE_TIMEOUT_EN
    // Watchdog: withhold done on the first read byte
    en1 = 1'b0;
    n   = log1.size();
    svb = sv1_cnt;
    start1 = 1'b1;
    repeat (4) step();
    start1 = 1'b0;
    ok = 1'b0;
    t0 = 0;
    for (int i = 0; i < 300; i++) begin
      step();
      if (to1) begin ok = 1'b1; t0 = cyc; break; end
    end
    check("to_flag_seen", 32'(ok), 32'd1);
    check("to_tx_count", 32'(log1.size() - n), 32'd1);
    if (ok && log1.size() == n + 1) begin
      check("to_addr", 32'(log1[n]), 32'hB400);
      check("to_latency", 32'(t0 - cyc1q[n]), 32'(TMO));
    end
    repeat (100) step();
    check("to_no_valid", 32'(sv1_cnt - svb), 32'd0);
    check("to_axis_kept", 32'(ad1), 32'h278);
    check("to_idle", 32'(busy1), 32'd0);
    check("to_sticky", 32'(to1), 32'd1);
    check("to_no_more_tx", 32'(log1.size() - n), 32'd1);
`else
    check("no_watchdog_dut1", 32'(to1), 32'd0);
    check("no_watchdog_dut3", 32'(to3), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/acl_axis_sequencer.md
Name: acl_axis_sequencer

Overview:
Parametrised SPI transaction sequencer for the ADXL345-class accelerometer behind the PmodACL. It sits between the SPI byte-pair interface (transmit/done/txdata/rxdata) and game logic. At power-up it writes a fixed three-register configuration. It then reads 1 to 3 axes per trigger, either single-shot or repeating while start is held. It presents all axis samples atomically with a valid strobe.

Parameters:
NUM_AXES, 3, axes read per sample set: 1=X, 2=X,Y, 3=X,Y,Z (legal 1..3)
FIRST_AXIS, 0, index of first axis read (0=X,1=Y,2=Z); FIRST_AXIS+NUM_AXES<=3
SAMPLE_W, 10, bits kept per axis (legal 9..16)
BREAK_CYCLES, 4096, idle clocks after every done before the next transfer
HOLD_CYCLES, 2097152, clocks between repeated sample sets while start stays high
DEBOUNCE, 3, consecutive high samples of start (after a low) required to trigger
TIMEOUT_CYCLES, 65535, done watchdog limit (used only with the optional feature)

Ports:
clk  in  1  system clock, 100 MHz
rst  in  1  synchronous active-high reset
start  in  1  user trigger, raw button level
rxdata  in  8  byte received in the completed transfer
done  in  1  one-cycle pulse: SPI transfer complete
transmit  out  1  one-cycle pulse: begin transfer of txdata
txdata  out  16  {address/RW byte, data byte}
axis_data  out  NUM_AXES*SAMPLE_W  packed samples; axis FIRST_AXIS in LSBs
sample_valid  out  1  one-cycle pulse when axis_data updates
config_done  out  1  high once configuration has completed
busy  out  1  high in any state except IDLE and HOLD
timeout_err  out  1  sticky watchdog flag (0 when the feature is compiled out)

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst, sampled on the rising edge of clk.
- Reset values: transmit=0, txdata=16'h0000, axis_data=0, sample_valid=0, config_done=0, busy=0, timeout_err=0. All counters=0, state=CFG_SEND, config index=0.
- Reset asserted mid-transfer: sequencer abandons the transfer and restarts configuration from POWER_CTL. A late done after reset is ignored.
- Configuration writes, in order: 16'h2D08, 16'h2C08, 16'h3100.
- Read address for axis a, low byte: 8'hB2+2a. High byte: 8'hB3+2a. txdata={addr,8'h00}.
- States:
  - CFG_SEND: drive txdata, pulse transmit -> CFG_WAIT.
  - CFG_WAIT: wait for done -> GAP.
  - GAP: count BREAK_CYCLES. If config is unfinished -> CFG_SEND with the next index. After the third write: set config_done and go to IDLE. During reads: go to RD_SEND with the next byte, or to COMMIT after the last byte.
  - IDLE: waits for a start trigger.
  - RD_SEND: pulse transmit -> RD_WAIT.
  - RD_WAIT: on done, latch rxdata into the shadow register -> GAP.
  - COMMIT: copy shadow to axis_data, pulse sample_valid for 1 cycle. If start=1 -> HOLD, else -> IDLE.
  - HOLD: count HOLD_CYCLES, then -> RD_SEND for the first axis. If start=0 at any point -> IDLE with the counter cleared.
- transmit is exactly one cycle wide. txdata is stable from the transmit cycle until done.
- done is ignored outside CFG_WAIT and RD_WAIT.
- Trigger: start_trig asserts when start has been sampled low, then high for DEBOUNCE consecutive clocks.
  - Acted on only in IDLE with config_done=1.
  - Triggers during configuration or reads are discarded, not queued.
- Byte order per axis: low byte then high byte. Axes are read in ascending index.
  - Low byte -> shadow[7:0].
  - High byte -> shadow[SAMPLE_W-1:8], taken from rxdata[SAMPLE_W-9:0]. Upper rxdata bits are discarded.
- axis_data never shows a partial set. It changes only in COMMIT.
- Total transfers per set: 2*NUM_AXES, each followed by a BREAK_CYCLES gap.
- Counters compare with ==, then clear. No wrap.

Optional Feature:
ACL_DONE_TIMEOUT_EN
- Defined: a watchdog runs in CFG_WAIT and RD_WAIT. If done is absent for TIMEOUT_CYCLES clocks, set timeout_err (sticky until rst), abort the set (axis_data unchanged, no sample_valid) and go to GAP. Configuration then retries the same register; a read set returns to IDLE.
- Undefined: no watchdog logic is present, the sequencer waits indefinitely, and timeout_err is tied to 0.

Test Plan:
- Release rst, respond to each transmit with done 20 clks later -> exactly 3 transmit pulses with txdata 2D08, 2C08, 3100, gaps >= BREAK_CYCLES, then config_done=1, busy=0.
- NUM_AXES=3, FIRST_AXIS=0, rxdata bytes 34,01,78,02,BC,03 -> txdata B200..B700 in order, one sample_valid, axis_data={10'h3BC,10'h278,10'h134}.
- NUM_AXES=1, FIRST_AXIS=1, SAMPLE_W=10, start held high -> reads B400/B500 repeat every HOLD_CYCLES. Drop start mid-HOLD -> IDLE within 1 clk and no further transmit.
- start pulse 2 clks (DEBOUNCE=3), or trigger during configuration -> no read transfer issued.
- rst asserted between transmit and done -> outputs at reset values next clk, late done ignored, configuration restarts at 2D08.
- With ACL_DONE_TIMEOUT_EN, TIMEOUT_CYCLES=100, withhold done on B400 -> timeout_err=1 at clk 100, no sample_valid, return to IDLE.
